branch_predict: RTL and testbench

BRANCH_PREDICT -- requirements
Module: branch_predict

---
 rtl/branch_predict.sv | 132 +++++++++++++
 tb/tb_branch_predict.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from fetchPC; every output is registered, giving one cycle of latency.
module branch_predict #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetchValid,
    input  logic [0:31] fetchPC,
    input  logic        updateValid,
    input  logic [0:65] PCpipe,
    output logic        predictValid,
    output logic        predictTaken,
    output logic [0:31] predictPC,
    output logic [0:15] mispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic             r_pred_vld_p1;
    logic             r_pred_taken_p1;
    logic [31:0]      r_pred_pc_p1;
    logic [15:0]      r_mis_cnt;

    // Internal copies use descending numbering: port bit 0 (MSB) becomes bit 31.
    logic [31:0]      w_fetch_pc;
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;
    logic [31:0]      w_f_seq;

    logic [31:0]      w_u_next;
    logic             w_u_taken;
    logic [31:0]      w_u_pc;
    logic             w_u_mis;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [1:0]       w_unused_pc_lsbs;

    assign w_fetch_pc = fetchPC;
    assign w_f_idx    = w_fetch_pc[2 +: IDX_W];
    assign w_f_tag    = w_fetch_pc[31 -: TAG_W];
    assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken  = w_f_hit && r_ctr[w_f_idx][1];
    assign w_f_seq    = (w_fetch_pc + 32'd8) & ~32'd7;

    assign w_u_next         = PCpipe[0:31];
    assign w_u_taken        = PCpipe[32];
    assign w_u_pc           = PCpipe[33:64];
    assign w_u_mis          = PCpipe[65];
    assign w_u_idx          = w_u_pc[2 +: IDX_W];
    assign w_u_tag          = w_u_pc[31 -: TAG_W];
    assign w_u_hit          = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_unused_pc_lsbs = w_u_pc[1:0];

    // Table write: lookup above sees the pre-update contents in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'd1;
            end
        end else if (updateValid) begin
            if (w_u_hit) begin
                if (w_u_taken) begin
                    r_ctr[w_u_idx]    <= ctr_inc(r_ctr[w_u_idx]);
                    r_target[w_u_idx] <= w_u_next;
                end else begin
                    r_ctr[w_u_idx]    <= ctr_dec(r_ctr[w_u_idx]);
                end
            end else if (w_u_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= w_u_next;
                r_ctr[w_u_idx]    <= 2'd2;
            end
        end
    end

    // Stage p1: registered prediction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_vld_p1   <= 1'b0;
            r_pred_taken_p1 <= 1'b0;
            r_pred_pc_p1    <= '0;
        end else if (fetchValid) begin
            r_pred_vld_p1   <= 1'b1;
            r_pred_taken_p1 <= w_f_taken;
            r_pred_pc_p1    <= w_f_taken ? r_target[w_f_idx] : w_f_seq;
        end else begin
            r_pred_vld_p1   <= 1'b0;
            r_pred_taken_p1 <= 1'b0;
            r_pred_pc_p1    <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mis_cnt <= '0;
        end else if (updateValid && w_u_mis) begin
            r_mis_cnt <= cnt_sat_inc(r_mis_cnt);
        end
    end

    assign predictValid    = r_pred_vld_p1;
    assign predictTaken    = r_pred_taken_p1;
    assign predictPC       = r_pred_pc_p1;
    assign mispredictCount = r_mis_cnt;

endmodule

// File: tb/tb_branch_predict.sv
// Bench for branch_predict: directed scenarios plus randomized traffic against a table model.
module tb_branch_predict;

    localparam int ENTRIES = 16;

    logic        clk;
    logic        reset;
    logic        fetchValid;
    logic [31:0] fetchPC;
    logic        updateValid;
    logic [65:0] PCpipe;
    logic        predictValid;
    logic        predictTaken;
    logic [31:0] predictPC;
    logic [15:0] mispredictCount;

    int n_checks;
    int n_fail;

    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_cnt;

    branch_predict #(.ENTRIES(ENTRIES)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetchValid     (fetchValid),
        .fetchPC        (fetchPC),
        .updateValid    (updateValid),
        .PCpipe         (PCpipe),
        .predictValid   (predictValid),
        .predictTaken   (predictTaken),
        .predictPC      (predictPC),
        .mispredictCount(mispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [65:0] mkpipe(input logic [31:0] nxt, input bit tk,
                                           input logic [31:0] bpc, input bit mis);
        return {nxt, tk, bpc, mis};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_cnt = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output bit tk, output logic [31:0] npc);
        int unsigned idx;
        int unsigned tg;
        logic [31:0] sum;
        idx = (pc / 4) % ENTRIES;
        tg  = pc / 64;
        if (m_valid[idx] && m_tag[idx] == tg && m_ctr[idx] >= 2) begin
            tk  = 1'b1;
            npc = m_target[idx];
        end else begin
            tk  = 1'b0;
            sum = pc + 32'd8;
            npc = (sum / 32'd8) * 32'd8;
        end
    endtask

    task automatic model_update(input logic [65:0] pp);
        logic [31:0] nxt;
        logic [31:0] bpc;
        bit          tk;
        int unsigned idx;
        int unsigned tg;
        nxt = pp[65:34];
        tk  = pp[33];
        bpc = pp[32:1];
        idx = (bpc / 4) % ENTRIES;
        tg  = bpc / 64;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            if (tk) begin
                if (m_ctr[idx] < 3) m_ctr[idx]++;
                m_target[idx] = nxt;
            end else if (m_ctr[idx] > 0) begin
                m_ctr[idx]--;
            end
        end else if (tk) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = tg;
            m_target[idx] = nxt;
            m_ctr[idx]    = 2;
        end
        if (pp[0] && m_cnt < 65535) m_cnt++;
    endtask

    task automatic cycle(input bit fv, input logic [31:0] fpc, input bit uv, input logic [65:0] pp);
        bit          etk;
        logic [31:0] epc;
        fetchValid  = fv;
        fetchPC     = fpc;
        updateValid = uv;
        PCpipe      = pp;
        model_predict(fpc, etk, epc);
        if (!fv) begin
            etk = 1'b0;
            epc = '0;
        end
        @(posedge clk);
        #1;
        if (uv) model_update(pp);
        check("pred_valid", 32'(predictValid), 32'(fv));
        check("pred_taken", 32'(predictTaken), 32'(etk));
        check("pred_pc", predictPC, epc);
        check("mis_count", 32'(mispredictCount), m_cnt);
    endtask

    task automatic idle_update(input logic [65:0] pp);
        cycle(1'b0, 32'h0, 1'b1, pp);
    endtask

    initial begin
        logic [31:0] fpc;
        logic [31:0] bpc;
        logic [31:0] tags [4];
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        fetchValid  = 1'b0;
        fetchPC     = '0;
        updateValid = 1'b0;
        PCpipe      = '0;
        model_reset();

        #12;
        check("rst_valid", 32'(predictValid), 32'h0);
        check("rst_taken", 32'(predictTaken), 32'h0);
        check("rst_pc", predictPC, 32'h0);
        check("rst_count", 32'(mispredictCount), 32'h0);
        #1 reset = 1'b0;

        // Cold miss
        cycle(1'b1, 32'h0000_0104, 1'b0, '0);
        check("cold_taken", 32'(predictTaken), 32'h0);
        check("cold_pc", predictPC, 32'h0000_0108);

        // Allocate then hit
        idle_update(mkpipe(32'h0000_0200, 1'b1, 32'h0000_0104, 1'b0));
        cycle(1'b1, 32'h0000_0104, 1'b0, '0);
        check("alloc_taken", 32'(predictTaken), 32'h1);
        check("alloc_pc", predictPC, 32'h0000_0200);

        // Hysteresis: 2 -> 1 -> 3
        idle_update(mkpipe(32'h0000_0108, 1'b0, 32'h0000_0104, 1'b0));
        cycle(1'b1, 32'h0000_0104, 1'b0, '0);
        check("hyst_nt_taken", 32'(predictTaken), 32'h0);
        check("hyst_nt_pc", predictPC, 32'h0000_0108);
        idle_update(mkpipe(32'h0000_0200, 1'b1, 32'h0000_0104, 1'b0));
        idle_update(mkpipe(32'h0000_0200, 1'b1, 32'h0000_0104, 1'b0));
        cycle(1'b1, 32'h0000_0104, 1'b0, '0);
        check("hyst_t_taken", 32'(predictTaken), 32'h1);

        // Aliasing on index 1
        cycle(1'b1, 32'h0000_1104, 1'b0, '0);
        check("alias_taken", 32'(predictTaken), 32'h0);
        check("alias_pc", predictPC, 32'h0000_1108);
        idle_update(mkpipe(32'h0000_0300, 1'b1, 32'h0000_1104, 1'b0));
        cycle(1'b1, 32'h0000_0104, 1'b0, '0);
        check("evicted_taken", 32'(predictTaken), 32'h0);
        check("evicted_pc", predictPC, 32'h0000_0108);
        cycle(1'b1, 32'h0000_1104, 1'b0, '0);
        check("alias_new_pc", predictPC, 32'h0000_0300);

        // Same-cycle fetch and allocating update at index 1
        cycle(1'b1, 32'h0000_2004, 1'b1, mkpipe(32'h0000_0400, 1'b1, 32'h0000_2004, 1'b0));
        check("rbw_taken", 32'(predictTaken), 32'h0);
        check("rbw_pc", predictPC, 32'h0000_2008);
        cycle(1'b1, 32'h0000_2004, 1'b0, '0);
        check("rbw_next_taken", 32'(predictTaken), 32'h1);
        check("rbw_next_pc", predictPC, 32'h0000_0400);

        // Address wrap and idle fetch
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, '0);
        check("wrap_pc", predictPC, 32'h0000_0000);
        cycle(1'b0, 32'h0000_2004, 1'b0, '0);
        check("nofetch_pc", predictPC, 32'h0000_0000);

        // A record presented without updateValid must be ignored
        cycle(1'b0, 32'h0, 1'b0, mkpipe(32'h0000_0500, 1'b1, 32'h0000_3008, 1'b1));
        cycle(1'b1, 32'h0000_3008, 1'b0, '0);
        check("ignored_pc", predictPC, 32'h0000_3010);

        // Mispredict counter
        idle_update(mkpipe(32'h0, 1'b0, 32'h0000_7000, 1'b1));
        idle_update(mkpipe(32'h0, 1'b0, 32'h0000_7000, 1'b1));
        idle_update(mkpipe(32'h0, 1'b0, 32'h0000_7000, 1'b1));
        idle_update(mkpipe(32'h0, 1'b0, 32'h0000_7000, 1'b0));
        check("miscnt3", 32'(mispredictCount), 32'd3);

        // Asynchronous reset between edges, with an allocating update held across an edge
        #3 reset = 1'b1;
        #1;
        check("arst_count", 32'(mispredictCount), 32'h0);
        check("arst_valid", 32'(predictValid), 32'h0);
        check("arst_taken", 32'(predictTaken), 32'h0);
        check("arst_pc", predictPC, 32'h0);
        model_reset();
        fetchValid  = 1'b1;
        fetchPC     = 32'h0000_0104;
        updateValid = 1'b1;
        PCpipe      = mkpipe(32'h0000_0200, 1'b1, 32'h0000_0104, 1'b1);
        @(posedge clk);
        #1;
        check("arst_hold_valid", 32'(predictValid), 32'h0);
        check("arst_hold_count", 32'(mispredictCount), 32'h0);
        #2 reset = 1'b0;
        cycle(1'b1, 32'h0000_0104, 1'b0, '0);
        check("post_rst_taken_a", 32'(predictTaken), 32'h0);
        cycle(1'b1, 32'h0000_2004, 1'b0, '0);
        check("post_rst_taken_b", 32'(predictTaken), 32'h0);

        // Randomized traffic over a small set of tags so entries collide and get reused
        tags[0] = 32'h0;
        tags[1] = 32'h1;
        tags[2] = 32'h2A;
        tags[3] = 32'h3FF_FFFF;
        for (int n = 0; n < 2000; n++) begin
            bit          fv;
            bit          uv;
            logic [65:0] pp;
            fv  = ($urandom % 4) != 0;
            uv  = ($urandom % 2) != 0;
            fpc = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2);
            bpc = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2);
            if (uv)
                pp = mkpipe($urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, bpc,
                            ($urandom % 4) == 0);
            else
                pp = {$urandom, $urandom, $urandom};
            cycle(fv, fpc, uv, pp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
